// File: rtl/adc_record_pkg.sv
// Shared definitions for the ADC record framer.
//   LEN_W_DEF  : default width of the record length and word counter
//   DROP_W_DEF : default width of the dropped-word counter
//   DATA_W     : sample word width on both AXI-stream interfaces
//   rec_state_e: record FSM states
package adc_record_pkg;

    localparam int unsigned LEN_W_DEF  = 32;
    localparam int unsigned DROP_W_DEF = 16;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } rec_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered output buffer for an AXI-stream master port.
//   clk, reset          : clock, synchronous active-high reset
//   wr_en_i             : write request (only honoured when wr_ok_o is high)
//   wr_data_i, wr_last_i: word and end-of-record flag to store
//   wr_ok_o             : a write this cycle would be stored; true when an
//                         entry is free or the head leaves this cycle
//   m_tvalid_o, m_tdata_o, m_tlast_o, m_tready_i : master stream
// The head entry drives the master port directly from registers, so there
// is no combinational path from the write side to the master outputs.
module axis_skid_buffer
    import adc_record_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         wr_last_i,
    output logic         wr_ok_o,
    output logic         m_tvalid_o,
    output logic [W-1:0] m_tdata_o,
    output logic         m_tlast_o,
    input  logic         m_tready_i
);

    logic [W-1:0] head_data_q, head_data_d;
    logic         head_last_q, head_last_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         skid_last_q, skid_last_d;
    logic [1:0]   count_q, count_d;

    logic pop;
    logic push;

    always_comb begin
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        count_d     = count_q;

        pop     = (count_q != 2'd0) && m_tready_i;
        // A full buffer still takes a word when the head is leaving now.
        wr_ok_o = (count_q != 2'd2) || m_tready_i;
        push    = wr_en_i && wr_ok_o;

        case (count_q)
            2'd0: begin
                if (push) begin
                    head_data_d = wr_data_i;
                    head_last_d = wr_last_i;
                    count_d     = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_data_d = wr_data_i;
                    head_last_d = wr_last_i;
                end else if (push) begin
                    skid_data_d = wr_data_i;
                    skid_last_d = wr_last_i;
                    count_d     = 2'd2;
                end else if (pop) begin
                    count_d     = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_data_d = skid_data_q;
                    head_last_d = skid_last_q;
                    if (push) begin
                        skid_data_d = wr_data_i;
                        skid_last_d = wr_last_i;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_data_q <= '0;
            head_last_q <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            count_q     <= count_d;
        end
    end

    assign m_tvalid_o = (count_q != 2'd0);
    assign m_tdata_o  = head_data_q;
    assign m_tlast_o  = head_last_q;

endmodule

// File: rtl/adc_record_framer.sv
// ADC record framer: cuts a fixed-length record out of a continuous sample
// stream, optionally waiting for an external trigger, and emits it as an
// AXI-stream packet terminated with tlast.
//   clk, reset                           : clock, synchronous active-high reset
//   s_axis_tvalid/tdata/tready           : sample input (always ready)
//   m_axis_tvalid/tdata/tkeep/tlast/tready : framed record output
//   start, start_rt, abort, trigger      : record control
//   record_len                           : words per record, latched on start
//   busy, done, overflow, dropped_cnt    : status
module adc_record_framer
    import adc_record_pkg::*;
#(
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned DROP_W = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_axis_tvalid,
    input  logic [31:0]       s_axis_tdata,
    output logic              s_axis_tready,
    output logic              m_axis_tvalid,
    output logic [31:0]       m_axis_tdata,
    output logic [3:0]        m_axis_tkeep,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    input  logic              start,
    input  logic              start_rt,
    input  logic              abort,
    input  logic              trigger,
    input  logic [LEN_W-1:0]  record_len,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DROP_W-1:0] dropped_cnt
);

    rec_state_e        state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              done_q, done_d;

    logic wr_en;
    logic wr_last;
    logic wr_ok;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        wr_last    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    overflow_d = 1'b0;
                    drop_d     = '0;
                    if (record_len == '0) begin
                        // Empty record completes immediately.
                        done_d = 1'b1;
                    end else begin
                        len_d   = record_len;
                        cnt_d   = '0;
                        state_d = start_rt ? ST_CAPTURE : ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (trigger) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (s_axis_tvalid) begin
                    if (wr_ok) begin
                        wr_en   = 1'b1;
                        // len_q >= 1 here, so len_q-1 never wraps.
                        wr_last = (cnt_q == (len_q - LEN_W'(1)));
                        cnt_d   = cnt_q + LEN_W'(1);
                        if (wr_last) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        overflow_d = 1'b1;
                        if (drop_q != '1) begin
                            drop_d = drop_q + DROP_W'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            done_q     <= done_d;
        end
    end

    axis_skid_buffer #(
        .W (32)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wr_en),
        .wr_data_i  (s_axis_tdata),
        .wr_last_i  (wr_last),
        .wr_ok_o    (wr_ok),
        .m_tvalid_o (m_axis_tvalid),
        .m_tdata_o  (m_axis_tdata),
        .m_tlast_o  (m_axis_tlast),
        .m_tready_i (m_axis_tready)
    );

    assign s_axis_tready = 1'b1;
    assign m_axis_tkeep  = 4'hF;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign dropped_cnt   = drop_q;

endmodule

// File: tb/tb_adc_record_framer.sv
module tb_adc_record_framer;

    localparam int M_IDLE = 0, M_ARMED = 1, M_CAPTURE = 2, M_DRAIN = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        start, start_rt, abort, trigger;
    logic [31:0] record_len;
    logic        busy, done, overflow;
    logic [15:0] dropped_cnt;

    int checks = 0;
    int errors = 0;

    // observed output beats
    logic [31:0] obs_data[$];
    logic        obs_last[$];
    int          n_done;

    // reference model of the record: FSM state, expected buffer contents
    int          mst;
    int          mlen, mcnt;
    logic [32:0] mq[$];
    logic        m_ovf;
    logic [15:0] m_drop;
    logic        done_pend;

    // per-cycle discrepancy counters, inspected by the test tasks
    int valid_err, done_err, busy_err, stab_err, data_err;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    always #5 clk = ~clk;

    adc_record_framer dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .start         (start),
        .start_rt      (start_rt),
        .abort         (abort),
        .trigger       (trigger),
        .record_len    (record_len),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .dropped_cnt   (dropped_cnt)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_obs();
        obs_data.delete();
        obs_last.delete();
        n_done    = 0;
        valid_err = 0;
        done_err  = 0;
        busy_err  = 0;
        stab_err  = 0;
        data_err  = 0;
    endtask

    // One clock cycle: observe outputs (stable since the last edge), advance
    // the reference model with the inputs currently driven, then clock.
    task automatic tick();
        logic pop, popped_last;
        if (m_axis_tvalid !== (mq.size() > 0)) valid_err++;
        if (done !== done_pend) done_err++;
        if (busy !== (mst != M_IDLE)) busy_err++;
        if (done === 1'b1) n_done++;
        if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
                           m_axis_tlast !== prev_last)) stab_err++;
        prev_stall = m_axis_tvalid && !m_axis_tready && !reset;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready && !reset) begin
            obs_data.push_back(m_axis_tdata);
            obs_last.push_back(m_axis_tlast);
            if (mq.size() > 0 && mq[0] !== {m_axis_tlast, m_axis_tdata}) data_err++;
        end

        done_pend   = 1'b0;
        pop         = (mq.size() > 0) && m_axis_tready;
        popped_last = 1'b0;
        if (pop) begin
            popped_last = mq[0][32];
            void'(mq.pop_front());
        end
        if (reset) begin
            mst    = M_IDLE;
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = '0;
            mcnt   = 0;
        end else begin
            case (mst)
                M_IDLE: if (start) begin
                    m_ovf  = 1'b0;
                    m_drop = '0;
                    if (record_len == 0) done_pend = 1'b1;
                    else begin
                        mlen = int'(record_len);
                        mcnt = 0;
                        mst  = start_rt ? M_CAPTURE : M_ARMED;
                    end
                end
                M_ARMED: begin
                    if (abort) mst = M_IDLE;
                    else if (trigger) mst = M_CAPTURE;
                end
                M_CAPTURE: if (s_axis_tvalid) begin
                    if (mq.size() < 2) begin
                        mq.push_back({(mcnt == mlen - 1), s_axis_tdata});
                        if (mcnt == mlen - 1) mst = M_DRAIN;
                        mcnt++;
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drop != 16'hFFFF) m_drop++;
                    end
                end
                default: if (popped_last) begin
                    mst       = M_IDLE;
                    done_pend = 1'b1;
                end
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_obs();
        reset = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEAD_BEEF;
        tick();
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        checks++; if ({busy, done, overflow} !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", {busy, done, overflow}); end
        checks++; if (dropped_cnt !== 16'h0) begin errors++; $display("FAIL reset_dropped got %0d want 0", dropped_cnt); end
        checks++; if (s_axis_tready !== 1'b1 || m_axis_tkeep !== 4'hF) begin errors++; $display("FAIL reset_ready_keep got %b/%h want 1/f", s_axis_tready, m_axis_tkeep); end
        reset = 1'b0;
        s_axis_tvalid = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_realtime();
        int bad = 0;
        clear_obs();
        m_axis_tready = 1'b1;
        start = 1'b1; start_rt = 1'b1; record_len = 32'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = i; tick();
        end
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (obs_data.size() !== 4) begin errors++; $display("FAIL rt_count got %0d want 4", obs_data.size()); end
        for (int i = 0; i < obs_data.size() && i < 4; i++)
            if (obs_data[i] !== 32'(i) || obs_last[i] !== (i == 3)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL rt_data got %0d bad beats want 0", bad); end
        checks++; if (n_done !== 1 || dropped_cnt !== 16'h0) begin errors++; $display("FAIL rt_done_drop got done=%0d drop=%0d want 1/0", n_done, dropped_cnt); end
        checks++; if (valid_err + done_err + busy_err + stab_err + data_err !== 0) begin errors++; $display("FAIL rt_model got %0d/%0d/%0d/%0d/%0d want 0", valid_err, done_err, busy_err, stab_err, data_err); end
        $display("test_realtime beats=%0d done=%0d", obs_data.size(), n_done);
    endtask

    task automatic test_trigger();
        int bad = 0;
        clear_obs();
        m_axis_tready = 1'b1;
        start = 1'b1; start_rt = 1'b0; record_len = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = i; trigger = (i == 5); tick();
        end
        s_axis_tvalid = 1'b0; trigger = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (obs_data.size() !== 3) begin errors++; $display("FAIL trig_count got %0d want 3", obs_data.size()); end
        for (int i = 0; i < obs_data.size() && i < 3; i++)
            if (obs_data[i] !== 32'(6 + i) || obs_last[i] !== (i == 2)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL trig_data got %0d bad beats want 0", bad); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL trig_done got %0d want 1", n_done); end
        checks++; if (valid_err + done_err + busy_err + stab_err + data_err !== 0) begin errors++; $display("FAIL trig_model got %0d/%0d/%0d/%0d/%0d want 0", valid_err, done_err, busy_err, stab_err, data_err); end
        $display("test_trigger beats=%0d first=%0d", obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : -1);
    endtask

    task automatic test_overflow();
        int bad = 0;
        int exp_d[8] = '{0, 1, 4, 5, 6, 7, 8, 9};
        clear_obs();
        m_axis_tready = 1'b1;
        start = 1'b1; start_rt = 1'b1; record_len = 32'd8;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = i; m_axis_tready = (i >= 4); tick();
        end
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (obs_data.size() !== 8) begin errors++; $display("FAIL ovf_count got %0d want 8", obs_data.size()); end
        for (int i = 0; i < obs_data.size() && i < 8; i++)
            if (obs_data[i] !== 32'(exp_d[i]) || obs_last[i] !== (i == 7)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_data got %0d bad beats want 0", bad); end
        checks++; if (overflow !== 1'b1 || dropped_cnt !== 16'd2) begin errors++; $display("FAIL ovf_status got ovf=%b drop=%0d want 1/2", overflow, dropped_cnt); end
        checks++; if (valid_err + done_err + busy_err + stab_err + data_err !== 0 || n_done !== 1) begin errors++; $display("FAIL ovf_model got errs=%0d done=%0d want 0/1", valid_err + done_err + busy_err + stab_err + data_err, n_done); end
        $display("test_overflow beats=%0d dropped=%0d", obs_data.size(), dropped_cnt);
    endtask

    task automatic test_abort();
        clear_obs();
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        start = 1'b1; start_rt = 1'b0; record_len = 32'd5;
        s_axis_tdata = $urandom; tick();
        start = 1'b0;
        s_axis_tdata = $urandom; tick();
        abort = 1'b1; trigger = 1'b1;
        s_axis_tdata = $urandom; tick();
        abort = 1'b0;
        for (int i = 0; i < 5; i++) begin s_axis_tdata = $urandom; tick(); end
        trigger = 1'b0;
        checks++; if (busy !== 1'b0 || obs_data.size() !== 0 || n_done !== 0) begin errors++; $display("FAIL abort got busy=%b beats=%0d done=%0d want 0/0/0", busy, obs_data.size(), n_done); end
        start = 1'b1; record_len = 32'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        s_axis_tvalid = 1'b0;
        checks++; if (n_done !== 1 || obs_data.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL len0 got done=%0d beats=%0d busy=%b want 1/0/0", n_done, obs_data.size(), busy); end
        checks++; if (valid_err + done_err + busy_err + stab_err + data_err !== 0) begin errors++; $display("FAIL abort_model got %0d/%0d/%0d/%0d/%0d want 0", valid_err, done_err, busy_err, stab_err, data_err); end
        $display("test_abort done=%0d beats=%0d", n_done, obs_data.size());
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        clear_obs();
        m_axis_tready = 1'b1;
        start = 1'b1; start_rt = 1'b1; record_len = 32'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && obs_data.size() < 2; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = 100 + i; tick();
        end
        checks++; if (obs_data.size() !== 2) begin errors++; $display("FAIL rstmid_pre got %0d beats want 2", obs_data.size()); end
        reset = 1'b1; m_axis_tready = 1'b0;
        tick();
        checks++; if (m_axis_tvalid !== 1'b0 || {busy, done, overflow} !== 3'b000 || dropped_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_status got v=%b b=%b d=%b o=%b c=%0d want all 0", m_axis_tvalid, busy, done, overflow, dropped_cnt); end
        checks++; if (valid_err + done_err + busy_err + stab_err + data_err !== 0) begin errors++; $display("FAIL rstmid_model got %0d/%0d/%0d/%0d/%0d want 0", valid_err, done_err, busy_err, stab_err, data_err); end
        reset = 1'b0; m_axis_tready = 1'b1; s_axis_tvalid = 1'b0;
        tick();
        clear_obs();
        start = 1'b1; record_len = 32'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin s_axis_tvalid = 1'b1; s_axis_tdata = 200 + i; tick(); end
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (obs_data.size() !== 2 || n_done !== 1) begin errors++; $display("FAIL rstmid_rec got beats=%0d done=%0d want 2/1", obs_data.size(), n_done); end
        for (int i = 0; i < obs_data.size() && i < 2; i++)
            if (obs_data[i] !== 32'(200 + i) || obs_last[i] !== (i == 1)) bad++;
        checks++; if (bad !== 0 || valid_err + done_err + busy_err + stab_err + data_err !== 0) begin errors++; $display("FAIL rstmid_data got bad=%0d errs=%0d want 0/0", bad, valid_err + done_err + busy_err + stab_err + data_err); end
        $display("test_reset_mid beats=%0d done=%0d", obs_data.size(), n_done);
    endtask

    task automatic test_random();
        int lasts = 0;
        int k;
        clear_obs();
        m_axis_tready = 1'b1;
        start = 1'b1; start_rt = 1'b1; record_len = 32'd100;
        tick();
        start = 1'b0;
        for (k = 0; k < 3000 && n_done == 0; k++) begin
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            s_axis_tdata  = $urandom;
            m_axis_tready = $urandom_range(0, 1) != 0;
            if (mst != M_IDLE) begin
                start      = ($urandom_range(0, 19) == 0);
                start_rt   = $urandom_range(0, 1) != 0;
                record_len = $urandom_range(0, 7);
                abort      = ($urandom_range(0, 9) == 0);
            end else begin
                start = 1'b0; abort = 1'b0;
            end
            tick();
        end
        start = 1'b0; abort = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        checks++; if (n_done !== 1) begin errors++; $display("FAIL rand_done got %0d after %0d cycles want 1", n_done, k); end
        for (int i = 0; i < 3; i++) tick();
        foreach (obs_last[i]) if (obs_last[i]) lasts++;
        checks++; if (obs_data.size() !== 100 || lasts !== 1 || obs_last[obs_last.size() - 1] !== 1'b1) begin errors++; $display("FAIL rand_beats got %0d beats %0d lasts want 100/1", obs_data.size(), lasts); end
        checks++; if (dropped_cnt !== m_drop || overflow !== m_ovf) begin errors++; $display("FAIL rand_drop got %0d/%b want %0d/%b", dropped_cnt, overflow, m_drop, m_ovf); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL rand_stable got %0d violations want 0", stab_err); end
        checks++; if (valid_err + done_err + busy_err + data_err !== 0) begin errors++; $display("FAIL rand_model got %0d/%0d/%0d/%0d want 0", valid_err, done_err, busy_err, data_err); end
        $display("test_random beats=%0d dropped=%0d cycles=%0d", obs_data.size(), dropped_cnt, k);
    endtask

    initial begin
        reset = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b1;
        start = 1'b0; start_rt = 1'b0; abort = 1'b0; trigger = 1'b0; record_len = '0;
        mst = M_IDLE; mlen = 0; mcnt = 0; m_ovf = 1'b0; m_drop = '0; done_pend = 1'b0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        clear_obs();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_realtime();
        test_trigger();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
